// File: rtl/ujtag_dbg_dr.sv
// JTAG user-DR bridge to the 8051 debug bus. Accesses start the UDRCK cycle after a DR update.
// There is no bus backpressure: an access waits in WR/RD for dbg_ack, and a start while busy is dropped and sets ovr.
module ujtag_dbg_dr #(
  parameter logic [31:0] USER_ID = 32'h8051_0001
) (
  input  logic        UDRCK,
  input  logic        URSTB,
  input  logic        UTDI,
  output logic        UTDO,
  input  logic        UDRCAP,
  input  logic        UDRSH,
  input  logic        UDRUPD,
  input  logic [7:0]  UIREG,
  output logic [15:0] dbg_addr,
  output logic [7:0]  dbg_wdata,
  output logic        dbg_req,
  output logic        dbg_we,
  input  logic        dbg_ack,
  input  logic [7:0]  dbg_rdata,
  output logic        cpu_halt,
  output logic        cpu_rst
);

  localparam logic [7:0] IR_USERID = 8'h10;
  localparam logic [7:0] IR_ADDR   = 8'h11;
  localparam logic [7:0] IR_WDATA  = 8'h12;
  localparam logic [7:0] IR_RDATA  = 8'h13;
  localparam logic [7:0] IR_CTRL   = 8'h14;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  logic [31:0] sr;
  logic [31:0] sr_shift;
  logic [31:0] cap_val;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdbuf;
  logic [1:0]  state;
  logic        autoinc;
  logic        ovr;
  logic        busy;
  logic        cap;
  logic        shf;
  logic        upd;
  logic        start_wr;
  logic        start_rd;
  logic        overrun;
  logic        done;

  assign cap  = UDRCAP & ~UDRSH;
  assign shf  = UDRCAP & UDRSH;
  assign upd  = UDRUPD;
  assign busy = (state != ST_IDLE);
  assign done = busy & dbg_ack;

  assign start_wr = upd && (UIREG == IR_WDATA) && !busy;
  assign start_rd = upd && (UIREG == IR_RDATA) && !busy;
  assign overrun  = upd && ((UIREG == IR_WDATA) || (UIREG == IR_RDATA)) && busy;

  assign UTDO      = sr[0];
  assign dbg_addr  = addr_q;
  assign dbg_wdata = wdata_q;
  // Derived from state so an async reset drops the request at once.
  assign dbg_req   = busy;
  assign dbg_we    = (state == ST_WR);

  always_comb begin
    sr_shift = {1'b0, sr[31:1]};
    cap_val  = 32'd0;
    case (UIREG)
      IR_USERID: begin
        sr_shift[31] = UTDI;
        cap_val      = USER_ID;
      end
      IR_ADDR: begin
        sr_shift[15]  = UTDI;
        cap_val[15:0] = addr_q;
      end
      IR_WDATA: begin
        sr_shift[7]  = UTDI;
        cap_val[7:0] = wdata_q;
      end
      IR_RDATA: begin
        sr_shift[8]  = UTDI;
        cap_val[8:0] = {busy, rdbuf};
      end
      IR_CTRL: begin
        sr_shift[7]  = UTDI;
        cap_val[7:0] = {4'b0000, ovr, autoinc, cpu_rst, cpu_halt};
      end
      default: sr_shift[0] = UTDI;
    endcase
  end

  always_ff @(posedge UDRCK or negedge URSTB) begin
    if (!URSTB) begin
      sr       <= 32'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 8'd0;
      rdbuf    <= 8'd0;
      state    <= ST_IDLE;
      autoinc  <= 1'b0;
      ovr      <= 1'b0;
      cpu_halt <= 1'b0;
      cpu_rst  <= 1'b0;
    end else begin
      if (cap) begin
        sr <= cap_val;
      end else if (shf) begin
        sr <= sr_shift;
      end

      // A JTAG address write wins over the post-ack increment.
      if (upd && (UIREG == IR_ADDR)) begin
        addr_q <= sr[15:0];
      end else if (done && autoinc) begin
        addr_q <= addr_q + 16'd1;
      end

      if (start_wr) begin
        wdata_q <= sr[7:0];
      end

      if (done && (state == ST_RD)) begin
        rdbuf <= dbg_rdata;
      end

      if (start_wr) begin
        state <= ST_WR;
      end else if (start_rd) begin
        state <= ST_RD;
      end else if (done) begin
        state <= ST_IDLE;
      end

      if (overrun) begin
        ovr <= 1'b1;
      end else if (upd && (UIREG == IR_CTRL) && sr[3]) begin
        ovr <= 1'b0;
      end

      if (upd && (UIREG == IR_CTRL)) begin
        cpu_halt <= sr[0];
        cpu_rst  <= sr[1];
        autoinc  <= sr[2];
      end
    end
  end

endmodule
